// File: rtl/core_pkg.sv
// Shared types for the multi-cycle core.
// Opcodes, special subcodes, FSM states, field helpers.
package core_pkg;

  localparam int IW = 9;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_ADC = 3'b001,
    OP_SUB = 3'b010,
    OP_XOR = 3'b011,
    OP_LD  = 3'b100,
    OP_ST  = 3'b101,
    OP_BZ  = 3'b110,
    OP_SPC = 3'b111
  } op_e;

  typedef enum logic [2:0] {
    SPC_HALT = 3'b000,
    SPC_CLC  = 3'b001,
    SPC_SHL  = 3'b010,
    SPC_SHR  = 3'b011
  } spc_e;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_MEM   = 2'd2,
    S_HALT  = 2'd3
  } state_e;

  function automatic op_e f_op(input logic [IW-1:0] ir);
    return op_e'(ir[8:6]);
  endfunction

  function automatic logic [2:0] f_ra(input logic [IW-1:0] ir);
    return ir[5:3];
  endfunction

  function automatic logic [2:0] f_rb(input logic [IW-1:0] ir);
    return ir[2:0];
  endfunction

endpackage

// File: rtl/multicycle_core_reg_file.sv
// Register file: two async read ports, one sync write.
// Whole array clears on the async reset.
module core_reg_file #(
  parameter int W = 8,
  parameter int D = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_we,
  input  logic [D-1:0] i_waddr,
  input  logic [W-1:0] i_wdata,
  input  logic [D-1:0] i_raddr_a,
  output logic [W-1:0] o_rdata_a,
  input  logic [D-1:0] i_raddr_b,
  output logic [W-1:0] o_rdata_b
);

  logic [W-1:0] r_mem [2**D];

  // Clear on reset, single write port otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem <= '{default: '0};
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = r_mem[i_raddr_a];
  assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/multicycle_core.sv
// Multi-cycle core: FETCH -> EXEC -> (MEM ->) FETCH.
// External imem/dmem reached through req/ack handshakes.
import core_pkg::*;

module multicycle_core #(
  parameter int DW  = 8,
  parameter int PCW = 10,
  parameter int CTW = 16
) (
  input  logic           CLK,
  input  logic           start_n,
  output logic           imem_req,
  output logic [PCW-1:0] imem_addr,
  input  logic           imem_ack,
  input  logic [IW-1:0]  imem_rdata,
  output logic           dmem_req,
  output logic           dmem_we,
  output logic [DW-1:0]  dmem_addr,
  output logic [DW-1:0]  dmem_wdata,
  input  logic           dmem_ack,
  input  logic [DW-1:0]  dmem_rdata,
  output logic           halt,
  output logic [CTW-1:0] cycle_ct,
  output logic [CTW-1:0] instr_ct
);

  state_e         r_state;
  logic [PCW-1:0] r_pc;
  logic [IW-1:0]  r_ir;
  logic           r_c;
  logic           r_halt;
  logic [CTW-1:0] r_cyc;
  logic [CTW-1:0] r_ict;

  op_e            w_op;
  logic [2:0]     w_ra;
  logic [2:0]     w_rb;
  logic [DW-1:0]  w_a;
  logic [DW-1:0]  w_b;
  logic [DW:0]    w_sum;
  logic [DW-1:0]  w_res;
  logic           w_c_nxt;
  logic           w_alu_we;
  logic           w_we;
  logic [DW-1:0]  w_wdata;
  logic           w_exec;
  logic           w_mem_done;
  logic           w_is_mem;
  logic           w_is_halt;
  logic           w_bz_take;
  logic           w_retire;
  logic [PCW-1:0] w_pc_inc;
  logic [PCW-1:0] w_pc_br;

  assign w_op = f_op(r_ir);
  assign w_ra = f_ra(r_ir);
  assign w_rb = f_rb(r_ir);

  core_reg_file #(.W(DW), .D(3)) u_rf (
    .clk       (CLK),
    .rst_n     (start_n),
    .i_we      (w_we),
    .i_waddr   (w_ra),
    .i_wdata   (w_wdata),
    .i_raddr_a (w_ra),
    .o_rdata_a (w_a),
    .i_raddr_b (w_rb),
    .o_rdata_b (w_b)
  );

  // ALU and special ops: result, next carry, writeback enable
  always_comb begin
    w_sum    = '0;
    w_res    = w_a;
    w_c_nxt  = r_c;
    w_alu_we = 1'b0;
    unique case (w_op)
      OP_ADD: begin
        w_sum    = {1'b0, w_a} + {1'b0, w_b};
        w_res    = w_sum[DW-1:0];
        w_c_nxt  = w_sum[DW];
        w_alu_we = 1'b1;
      end
      OP_ADC: begin
        w_sum    = {1'b0, w_a} + {1'b0, w_b}
                 + (DW+1)'(r_c);
        w_res    = w_sum[DW-1:0];
        w_c_nxt  = w_sum[DW];
        w_alu_we = 1'b1;
      end
      OP_SUB: begin
        w_sum    = {1'b0, w_a} - {1'b0, w_b};
        w_res    = w_sum[DW-1:0];
        w_c_nxt  = w_sum[DW];
        w_alu_we = 1'b1;
      end
      OP_XOR: begin
        w_res    = w_a ^ w_b;
        w_alu_we = 1'b1;
      end
      OP_SPC: begin
        unique case (1'b1)
          (w_rb == SPC_CLC): w_c_nxt = 1'b0;
          (w_rb == SPC_SHL): begin
            w_res    = {w_a[DW-2:0], r_c};
            w_c_nxt  = w_a[DW-1];
            w_alu_we = 1'b1;
          end
          (w_rb == SPC_SHR): begin
            w_res    = {r_c, w_a[DW-1:1]};
            w_c_nxt  = w_a[0];
            w_alu_we = 1'b1;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign w_exec     = (r_state == S_EXEC);
  assign w_mem_done = (r_state == S_MEM) && dmem_ack;
  assign w_is_mem   = (w_op == OP_LD) || (w_op == OP_ST);
  assign w_is_halt  = (w_op == OP_SPC) && (w_rb == SPC_HALT);
  assign w_bz_take  = (w_op == OP_BZ) && (w_a == '0);
  assign w_pc_inc   = r_pc + PCW'(1);
  assign w_pc_br    = r_pc + {{(PCW-3){w_rb[2]}}, w_rb};
  assign w_retire   = (w_exec && !w_is_mem) || w_mem_done;

  assign w_we    = (w_exec && w_alu_we)
                 || (w_mem_done && (w_op == OP_LD));
  assign w_wdata = w_mem_done ? dmem_rdata : w_res;

  // Control FSM: PC, IR, carry and halt flag
  always_ff @(posedge CLK or negedge start_n) begin
    if (!start_n) begin
      r_state <= S_FETCH;
      r_pc    <= '0;
      r_ir    <= '0;
      r_c     <= 1'b0;
      r_halt  <= 1'b0;
    end else begin
      unique case (r_state)
        S_FETCH: begin
          if (imem_ack) begin
            r_ir    <= imem_rdata;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_c <= w_c_nxt;
          if (w_is_mem) begin
            r_state <= S_MEM;
          end else if (w_is_halt) begin
            r_state <= S_HALT;
            r_halt  <= 1'b1;
          end else begin
            r_state <= S_FETCH;
            r_pc    <= w_bz_take ? w_pc_br : w_pc_inc;
          end
        end
        S_MEM: begin
          if (dmem_ack) begin
            r_pc    <= w_pc_inc;
            r_state <= S_FETCH;
          end
        end
        default: ;
      endcase
    end
  end

  // Saturating cycle and retire counters
  always_ff @(posedge CLK or negedge start_n) begin
    if (!start_n) begin
      r_cyc <= '0;
      r_ict <= '0;
    end else begin
      if (!r_halt && (r_cyc != '1))
        r_cyc <= r_cyc + CTW'(1);
      if (w_retire && (r_ict != '1))
        r_ict <= r_ict + CTW'(1);
    end
  end

  // Request is gated by reset so it never shows during reset
  assign imem_req   = start_n && (r_state == S_FETCH);
  assign imem_addr  = r_pc;
  assign dmem_req   = (r_state == S_MEM);
  assign dmem_we    = dmem_req && (w_op == OP_ST);
  assign dmem_addr  = w_b;
  assign dmem_wdata = w_a;
  assign halt       = r_halt;
  assign cycle_ct   = r_cyc;
  assign instr_ct   = r_ict;

endmodule
